// File: rtl/sd_clk_pkg.sv
// Shared constants and types for the SD clock generator.
package sd_clk_pkg;

    // Default divider configuration for a 100 MHz system clock.
    localparam int unsigned SD_DIV_W    = 8;
    localparam int unsigned SD_SLOW_DIV = 124;  // 400 kHz identification clock
    localparam int unsigned SD_FAST_DIV = 1;    // 25 MHz transfer clock

    // Mode select encoding; 2'b11 is reserved and behaves as slow.
    localparam logic [1:0] MODE_SLOW = 2'b00;
    localparam logic [1:0] MODE_FAST = 2'b01;
    localparam logic [1:0] MODE_CUS  = 2'b10;

    // One-hot clock state, decoded from the SD clock level and the halt flag.
    typedef enum logic [2:0] {
        RUN_LO  = 3'b001,
        RUN_HI  = 3'b010,
        HALT_LO = 3'b100
    } clk_state_e;

endpackage

// File: rtl/sd_clk_phase_cnt.sv
// Half-period counter: counts up to term and flags the last cycle of a phase.
module sd_clk_phase_cnt #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] term,
    input  logic             en,
    output logic             phase_end
);

    logic [DIV_W-1:0] cnt;

    // Last cycle of the current phase.
    always_comb phase_end = (cnt == term);

    // Count while enabled; wrap to zero at phase end, freeze when disabled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            if (phase_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_clk_gen.sv
// SD clock generator: even-ratio divider of iclk with slow/fast/custom modes.
// Divisor changes take effect only at the end of a low phase, so no runt pulses.
// Optional macro SD_CLK_STOP_EN enables the ihold clock-stop feature.
module sd_clk_gen
    import sd_clk_pkg::*;
#(
    parameter int unsigned DIV_W    = SD_DIV_W,
    parameter int unsigned SLOW_DIV = SD_SLOW_DIV,
    parameter int unsigned FAST_DIV = SD_FAST_DIV
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic [1:0]       isel_clk,
    input  logic             idiv_wr,
    input  logic [DIV_W-1:0] idiv,
    input  logic             ihold,
    output logic             oclk_sd,
    output logic             ostb_rise,
    output logic             ostb_fall,
    output logic             olocked,
    output logic             ohalted
);

    localparam logic [DIV_W-1:0] SLOW_V = DIV_W'(SLOW_DIV);
    localparam logic [DIV_W-1:0] FAST_V = DIV_W'(FAST_DIV);

    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_cus;
    logic [DIV_W-1:0] div_req;
    logic [DIV_W-1:0] div_act_nxt;
    logic             phase_end;
    logic             stall;
    logic             apply;
    clk_state_e       state;

    // Requested divisor from the mode select; reserved mode falls back to slow.
    always_comb begin
        div_req = SLOW_V;
        case (isel_clk)
            MODE_FAST: div_req = FAST_V;
            MODE_CUS:  div_req = div_cus;
            default:   div_req = SLOW_V;
        endcase
    end

`ifdef SD_CLK_STOP_EN
    // State view of the clock; halt only ever happens with the clock low.
    always_comb begin
        if (ohalted) begin
            state = HALT_LO;
        end else if (oclk_sd) begin
            state = RUN_HI;
        end else begin
            state = RUN_LO;
        end
    end

    // Hold only bites at the end of a low phase; a high phase always completes.
    always_comb stall = ihold && phase_end && (state != RUN_HI);
`else
    logic unused_hold;
    assign unused_hold = ihold;
    assign ohalted     = 1'b0;

    // State view of the clock without the stop feature.
    always_comb state = oclk_sd ? RUN_HI : RUN_LO;

    // Without the stop feature the clock never stalls.
    always_comb stall = 1'b0;
`endif

    // Apply the pending divisor on the rising edge that starts a new high phase.
    always_comb begin
        apply       = phase_end && (state != RUN_HI) && !stall;
        div_act_nxt = apply ? div_req : div_act;
    end

    sd_clk_phase_cnt #(
        .DIV_W (DIV_W)
    ) u_phase_cnt (
        .clk       (iclk),
        .rst_n     (irst_n),
        .term      (div_act),
        .en        (!stall),
        .phase_end (phase_end)
    );

    // Clock FSM, strobes, divisor registers and lock status.
    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            oclk_sd   <= 1'b0;
            ostb_rise <= 1'b0;
            ostb_fall <= 1'b0;
            olocked   <= 1'b1;
            div_act   <= SLOW_V;
            div_cus   <= SLOW_V;
`ifdef SD_CLK_STOP_EN
            ohalted   <= 1'b0;
`endif
        end else begin
            ostb_rise <= 1'b0;
            ostb_fall <= 1'b0;
            div_act   <= div_act_nxt;
            olocked   <= (div_act_nxt == div_req);
            if (idiv_wr) begin
                div_cus <= idiv;
            end
            if (phase_end) begin
                unique case (state)
                    RUN_HI: begin
                        oclk_sd   <= 1'b0;
                        ostb_fall <= 1'b1;
                    end
`ifdef SD_CLK_STOP_EN
                    RUN_LO, HALT_LO: begin
                        if (stall) begin
                            ohalted <= 1'b1;
                        end else begin
                            oclk_sd   <= 1'b1;
                            ostb_rise <= 1'b1;
                            ohalted   <= 1'b0;
                        end
                    end
`else
                    RUN_LO: begin
                        oclk_sd   <= 1'b1;
                        ostb_rise <= 1'b1;
                    end
`endif
                    default: oclk_sd <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sd_clk_gen.sv
// Self-checking bench for sd_clk_gen with a phase-length reference model.
module tb_sd_clk_gen;

    localparam int unsigned DIV_W = 8;
    localparam int          SLOW  = 124;
    localparam int          FAST  = 1;
`ifdef SD_CLK_STOP_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic             iclk = 1'b0;
    logic             irst_n;
    logic [1:0]       isel_clk;
    logic             idiv_wr;
    logic [DIV_W-1:0] idiv;
    logic             ihold;
    logic             oclk_sd;
    logic             ostb_rise;
    logic             ostb_fall;
    logic             olocked;
    logic             ohalted;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: current level, cycles left in this phase, divisors.
    bit m_lvl, m_halted, m_rise, m_fall, m_locked;
    int m_rem, m_act, m_cus;

    // Observed phase-length tracking.
    bit len_chk = 1'b0;
    logic prev_lvl = 1'b0;
    int run_len = 0;

    always #5 iclk = ~iclk;

    sd_clk_gen #(
        .DIV_W    (DIV_W),
        .SLOW_DIV (SLOW),
        .FAST_DIV (FAST)
    ) dut (
        .iclk      (iclk),
        .irst_n    (irst_n),
        .isel_clk  (isel_clk),
        .idiv_wr   (idiv_wr),
        .idiv      (idiv),
        .ihold     (ihold),
        .oclk_sd   (oclk_sd),
        .ostb_rise (ostb_rise),
        .ostb_fall (ostb_fall),
        .olocked   (olocked),
        .ohalted   (ohalted)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int req_div(input logic [1:0] mode, input int cus);
        if (mode == 2'b01) return FAST;
        if (mode == 2'b10) return cus;
        return SLOW;
    endfunction

    // One rising edge of the model: phases last div+1 cycles each.
    task automatic model_step();
        int req;
        int nact;
        req = req_div(isel_clk, m_cus);
        if (!irst_n) begin
            m_lvl = 0; m_halted = 0; m_rise = 0; m_fall = 0; m_locked = 1;
            m_act = SLOW; m_cus = SLOW; m_rem = SLOW + 1;
            return;
        end
        m_rise = 0;
        m_fall = 0;
        nact   = m_act;
        if (m_rem == 1) begin
            if (m_lvl) begin
                m_lvl = 0; m_fall = 1; m_rem = m_act + 1;
            end else if (HOLD_EN && ihold) begin
                m_halted = 1;
            end else begin
                nact = req; m_lvl = 1; m_rise = 1; m_halted = 0; m_rem = nact + 1;
            end
        end else begin
            m_rem--;
        end
        m_locked = (nact == req);
        m_act    = nact;
        if (idiv_wr) m_cus = int'(idiv);
    endtask

    task automatic tick();
        @(posedge iclk);
        model_step();
        @(negedge iclk);
        check_val("oclk_sd", oclk_sd, m_lvl);
        check_val("ostb_rise", ostb_rise, m_rise);
        check_val("ostb_fall", ostb_fall, m_fall);
        check_val("olocked", olocked, m_locked);
        check_val("ohalted", ohalted, m_halted);
        if (oclk_sd !== prev_lvl) begin
            if (len_chk) check_val("min_phase", 32'(run_len >= 2), 1);
            prev_lvl = oclk_sd;
            run_len  = 1;
        end else begin
            run_len++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Tick until a rise strobe is seen; n returns the number of ticks taken.
    task automatic wait_rise(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ostb_rise !== 1'b1 && n < budget);
        if (ostb_rise !== 1'b1) check_val("wait_rise_timeout", ostb_rise, 1);
    endtask

    initial begin
        int n;
        int len;
        irst_n   = 1'b0;
        isel_clk = 2'b00;
        idiv_wr  = 1'b0;
        idiv     = '0;
        ihold    = 1'b0;

        // Reset values.
        ticks(3);
        check_val("rst_clk", oclk_sd, 0);
        check_val("rst_lock", olocked, 1);
        check_val("rst_halt", ohalted, 0);

        // Slow mode: first rise after 125 cycles, then period 250.
        irst_n = 1'b1;
        wait_rise(400, n);
        check_val("slow_first_rise", n, 125);
        wait_rise(600, n);
        check_val("slow_period", n, 250);

        // Switch to fast in the middle of a high phase.
        ticks(60);
        isel_clk = 2'b01;
        len_chk  = 1'b1;
        tick();
        check_val("fast_lock_drop", olocked, 0);
        ticks(400);
        len_chk  = 1'b0;
        wait_rise(20, n);
        wait_rise(20, n);
        check_val("fast_period", n, 4);

        // Custom divisor 0: clock toggles every cycle.
        idiv     = 8'd0;
        idiv_wr  = 1'b1;
        tick();
        idiv_wr  = 1'b0;
        isel_clk = 2'b10;
        wait_rise(20, n);
        wait_rise(20, n);
        check_val("cus0_period", n, 2);
        ticks(20);

        // Reserved mode behaves as slow.
        isel_clk = 2'b11;
        wait_rise(20, n);
        wait_rise(600, n);
        check_val("mode11_period", n, 250);

        // Randomised modes, divisor writes and holds.
        for (int s = 0; s < 24; s++) begin
            isel_clk = 2'($urandom_range(0, 3));
            len      = int'($urandom_range(40, 400));
            for (int c = 0; c < len; c++) begin
                idiv_wr = ($urandom_range(0, 49) == 0);
                idiv    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                      : 8'($urandom_range(0, 9));
                if ($urandom_range(0, 19) == 0) ihold = ~ihold;
                tick();
            end
        end
        idiv_wr = 1'b0;
        ihold   = 1'b0;
        ticks(4);

        // Fast mode settles before the hold and reset scenarios.
        isel_clk = 2'b01;
        wait_rise(800, n);
        wait_rise(20, n);
        wait_rise(20, n);
        check_val("fast_period2", n, 4);

`ifdef SD_CLK_STOP_EN
        // Hold raised in a high phase: high completes, low completes, then halt.
        ihold = 1'b1;
        ticks(8);
        check_val("halt_flag", ohalted, 1);
        check_val("halt_clk", oclk_sd, 0);
        // A request change while halted stays pending until release.
        isel_clk = 2'b00;
        tick();
        check_val("halt_pending_lock", olocked, 0);
        ihold = 1'b0;
        tick();
        check_val("release_rise", ostb_rise, 1);
        check_val("release_halt", ohalted, 0);
        check_val("release_lock", olocked, 1);
        wait_rise(600, n);
        check_val("post_release_period", n, 250);
`endif

        // Reset while high in custom mode; custom register returns to slow.
        idiv     = 8'd5;
        idiv_wr  = 1'b1;
        tick();
        idiv_wr  = 1'b0;
        isel_clk = 2'b10;
        wait_rise(600, n);
        wait_rise(20, n);
        check_val("cus5_period", n, 12);
        ticks(2);
        irst_n = 1'b0;
        tick();
        check_val("midrst_clk", oclk_sd, 0);
        check_val("midrst_lock", olocked, 1);
        irst_n = 1'b1;
        wait_rise(400, n);
        check_val("midrst_first_rise", n, 125);
        wait_rise(600, n);
        check_val("midrst_period", n, 250);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
